// File: rtl/and_or_pkg.sv
// rtl/and_or_pkg.sv - shared width default and operation-select encoding for and_or
package and_or_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_NONE = 2'b00;
  localparam op_t OP_OR   = 2'b01;
  localparam op_t OP_AND  = 2'b10;

  // AND takes priority when both requests are present in the same cycle.
  function automatic op_t encode_op(input logic do_and, input logic do_or);
    op_t op;
    if (do_and) begin
      op = OP_AND;
    end else if (do_or) begin
      op = OP_OR;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/and_or_comb.sv
// rtl/and_or_comb.sv - combinational bitwise AND/OR selector with hold path
module and_or_comb
  import and_or_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hold,
  output logic [WIDTH-1:0] result,
  output logic             is_and
);

  always_comb begin
    result = hold;
    is_and = 1'b0;
    case (op)
      OP_AND: begin
        result = a & b;
        is_and = 1'b1;
      end
      OP_OR:   result = a | b;
      default: result = hold;
    endcase
  end

endmodule

// File: rtl/and_or.sv
// rtl/and_or.sv - registered bitwise AND/OR unit with asynchronous active-high reset
module and_or
  import and_or_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic             doAnd,
  input  logic             doOr,
  output logic             isAnd,
  output logic [WIDTH-1:0] out
);

  op_t              op;
  logic [WIDTH-1:0] result_next;
  logic             is_and_next;

  assign op = encode_op(doAnd, doOr);

  and_or_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .op    (op),
    .a     (aIn),
    .b     (bIn),
    .hold  (out),
    .result(result_next),
    .is_and(is_and_next)
  );

  // Idle cycles keep the last result but always clear isAnd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= '0;
      isAnd <= 1'b0;
    end else begin
      out   <= result_next;
      isAnd <= is_and_next;
    end
  end

endmodule

// File: tb/tb_and_or.sv
// tb/tb_and_or.sv - directed self-checking bench for and_or
module tb_and_or;

  logic       clk;
  logic       rst;
  logic [3:0] aIn;
  logic [3:0] bIn;
  logic       doAnd;
  logic       doOr;
  logic       isAnd;
  logic [3:0] out;

  int passed;
  int total;

  and_or #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .aIn  (aIn),
    .bIn  (bIn),
    .doAnd(doAnd),
    .doOr (doOr),
    .isAnd(isAnd),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [3:0] exp);
    total++;
    assert (out === exp) passed++;
    else $error("FAIL %s: out observed=%b expected=%b", tag, out, exp);
  endtask

  task automatic check_flag(input string tag, input logic exp);
    total++;
    assert (isAnd === exp) passed++;
    else $error("FAIL %s: isAnd observed=%b expected=%b", tag, isAnd, exp);
  endtask

  // Drive one request, let one rising edge sample it, then look 1ns later.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic da, input logic dor);
    aIn   = a;
    bIn   = b;
    doAnd = da;
    doOr  = dor;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ea;
    logic [3:0] eb;
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    aIn    = 4'b0000;
    bIn    = 4'b0000;
    doAnd  = 1'b0;
    doOr   = 1'b0;

    #2;
    check_out("reset_out", 4'b0000);
    check_flag("reset_isand", 1'b0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_out("release_hold_out", 4'b0000);
    check_flag("release_hold_isand", 1'b0);

    step(4'b1100, 4'b1010, 1'b1, 1'b0);
    check_out("and_basic_out", 4'b1000);
    check_flag("and_basic_isand", 1'b1);

    step(4'b1100, 4'b1010, 1'b0, 1'b1);
    check_out("or_basic_out", 4'b1110);
    check_flag("or_basic_isand", 1'b0);

    step(4'b0011, 4'b0001, 1'b0, 1'b0);
    check_out("idle_hold1_out", 4'b1110);
    check_flag("idle_hold1_isand", 1'b0);
    step(4'b0110, 4'b1001, 1'b0, 1'b0);
    check_out("idle_hold2_out", 4'b1110);
    check_flag("idle_hold2_isand", 1'b0);

    step(4'b1111, 4'b0101, 1'b1, 1'b1);
    check_out("and_priority_out", 4'b0101);
    check_flag("and_priority_isand", 1'b1);

    // Mid-cycle async reset with a nonzero result and no clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset_out", 4'b0000);
    check_flag("async_reset_isand", 1'b0);

    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    check_out("reset_held_out", 4'b0000);
    check_flag("reset_held_isand", 1'b0);
    rst = 1'b0;

    step(4'b1100, 4'b1010, 1'b1, 1'b0);
    check_out("post_reset_and_out", 4'b1000);
    check_flag("post_reset_and_isand", 1'b1);

    step(4'b1100, 4'b1010, 1'b0, 1'b0);
    check_out("post_and_idle_out", 4'b1000);
    check_flag("post_and_idle_isand", 1'b0);

    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          ea = 4'(a);
          eb = 4'(b);
          if (op == 0) begin
            step(ea, eb, 1'b1, 1'b0);
            check_out($sformatf("sweep_and_out_a%0d_b%0d", a, b), ea & eb);
            check_flag($sformatf("sweep_and_isand_a%0d_b%0d", a, b), 1'b1);
          end else begin
            step(ea, eb, 1'b0, 1'b1);
            check_out($sformatf("sweep_or_out_a%0d_b%0d", a, b), ea | eb);
            check_flag($sformatf("sweep_or_isand_a%0d_b%0d", a, b), 1'b0);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
